// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and sizing helpers for the fetch aligner/instruction buffer.
//   ILEN          instruction width (fixed at 32)
//   PC_XLEN       PC width stored per buffer entry; the top-level XLEN must equal it
//   fetch_entry_t one buffered instruction together with its PC
//   off_width     bits of the in-group slot offset (FETCH_W >= 2)
//   ptr_width     circular-queue pointer width
//   cnt_width     occupancy counter width (must be able to hold DEPTH itself)
package fetch_pkg;

    localparam int ILEN    = 32;
    localparam int PC_XLEN = 32;

    typedef struct packed {
        logic [ILEN-1:0]    instr;
        logic [PC_XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic int off_width(input int fetch_w);
        return $clog2(fetch_w);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_ibuf_mem.sv
// fetch_ibuf_mem: DEPTH-entry circular storage of fetch_entry_t.
//   clk, rst_n   clock and synchronous active-low reset (clears every entry)
//   wr_base      index written by write port 0; port p writes wr_base+p (mod DEPTH)
//   wr_en        per-port write enable
//   wr_data      per-port entry
//   rd_base      index read by read port 0; port j reads rd_base+j (mod DEPTH)
//   rd_data      combinational read data per read port
module fetch_ibuf_mem
    import fetch_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = ptr_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PTR_W-1:0]   wr_base,
    input  logic [FETCH_W-1:0] wr_en,
    input  fetch_entry_t       wr_data [FETCH_W],
    input  logic [PTR_W-1:0]   rd_base,
    output fetch_entry_t       rd_data [ISSUE_W]
);

    fetch_entry_t mem_r [DEPTH];

    // Storage array: cleared on reset, otherwise each enabled port writes its consecutive entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            // FETCH_W <= DEPTH, so two ports never target the same entry.
            for (int p = 0; p < FETCH_W; p++) begin
                if (wr_en[p]) begin
                    mem_r[wr_base + PTR_W'(p)] <= wr_data[p];
                end else begin
                    mem_r[wr_base + PTR_W'(p)] <= mem_r[wr_base + PTR_W'(p)];
                end
            end
        end
    end

    for (genvar j = 0; j < ISSUE_W; j++) begin : g_rd
        assign rd_data[j] = mem_r[rd_base + PTR_W'(j)];
    end

endmodule

// File: rtl/fetch_align_buf.sv
// fetch_align_buf: fetch aligner and in-order instruction buffer feeding decode.
//   clk, rst_n    clock and synchronous active-low reset
//   i_pc          address presented to the icache this cycle
//   i_cache_vld   cache data valid for the previously latched PC
//   i_cache_dat   fetch group, slot k at bits [32k+31:32k]
//   i_flush       redirect; i_pc carries the target, queue is emptied
//   i_dec_rdy     decode accepts every valid output slot this cycle
//   o_fetch_rdy   room for a full fetch group (PC gen/cache stall when low)
//   o_instr/o_pc  up to ISSUE_W oldest instructions and their PCs, slot 0 oldest
//   o_instr_vld   thermometer valid, slot 0 first
//   o_count       occupied entries
module fetch_align_buf
    import fetch_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int XLEN    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [XLEN-1:0]           i_pc,
    input  logic                      i_cache_vld,
    input  logic [FETCH_W*32-1:0]     i_cache_dat,
    input  logic                      i_flush,
    input  logic                      i_dec_rdy,
    output logic                      o_fetch_rdy,
    output logic [ISSUE_W*32-1:0]     o_instr,
    output logic [ISSUE_W*XLEN-1:0]   o_pc,
    output logic [ISSUE_W-1:0]        o_instr_vld,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int OFF_W = off_width(FETCH_W);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [XLEN-1:0]    pc_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic [OFF_W-1:0]   off_s;
    logic               fetch_rdy_s;
    logic               enq_s;
    logic               deq_s;
    logic [CNT_W-1:0]   n_in_s;
    logic [CNT_W-1:0]   n_out_s;
    logic [FETCH_W-1:0] wr_en_s;
    fetch_entry_t       wr_data_s [FETCH_W];
    fetch_entry_t       rd_data_s [ISSUE_W];

    // Offset of the latched PC inside its fetch group; slots below it are dropped.
    assign off_s       = pc_r[OFF_W+1:2];
    // count never exceeds DEPTH, so the subtraction cannot wrap.
    assign fetch_rdy_s = ((CNT_W'(DEPTH) - count_r) >= CNT_W'(FETCH_W));
    assign enq_s       = i_cache_vld & fetch_rdy_s & ~i_flush;
    assign deq_s       = i_dec_rdy & ~i_flush;

    // Compaction: write port p carries group slot off+p, so surviving slots land contiguously.
    for (genvar p = 0; p < FETCH_W; p++) begin : g_wr
        logic [OFF_W:0]   sel_s;
        logic [OFF_W-1:0] slot_s;
        assign sel_s        = {1'b0, off_s} + (OFF_W+1)'(p);
        assign slot_s       = sel_s[OFF_W-1:0];
        assign wr_en_s[p]   = enq_s & (sel_s < (OFF_W+1)'(FETCH_W));
        assign wr_data_s[p] = {i_cache_dat[{slot_s, 5'b00000} +: 32],
                               pc_r[XLEN-1:OFF_W+2], slot_s, pc_r[1:0]};
    end

    // Entry counts moved in and out this cycle.
    always_comb begin
        n_in_s  = '0;
        n_out_s = '0;
        if (enq_s) begin
            n_in_s = CNT_W'(FETCH_W) - CNT_W'(off_s);
        end else begin
            n_in_s = '0;
        end
        if (deq_s) begin
            if (count_r < CNT_W'(ISSUE_W)) begin
                n_out_s = count_r;
            end else begin
                n_out_s = CNT_W'(ISSUE_W);
            end
        end else begin
            n_out_s = '0;
        end
    end

    // PC latch, queue pointers and occupancy; flush overrides everything but reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r     <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (i_flush) begin
            pc_r     <= i_pc;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (fetch_rdy_s) begin
                pc_r <= i_pc;
            end else begin
                pc_r <= pc_r;
            end
            wr_ptr_r <= wr_ptr_r + PTR_W'(n_in_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(n_out_s);
            count_r  <= count_r + n_in_s - n_out_s;
        end
    end

    fetch_ibuf_mem #(
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_base (wr_ptr_r),
        .wr_en   (wr_en_s),
        .wr_data (wr_data_s),
        .rd_base (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    for (genvar j = 0; j < ISSUE_W; j++) begin : g_out
        assign o_instr[j*32 +: 32]     = rd_data_s[j].instr;
        assign o_pc[j*XLEN +: XLEN]    = rd_data_s[j].pc;
        assign o_instr_vld[j]          = (CNT_W'(j) < count_r);
    end

    assign o_count     = count_r;
    assign o_fetch_rdy = fetch_rdy_s;

endmodule

// File: tb/tb_fetch_align_buf.sv
// tb_fetch_align_buf: scoreboard bench for fetch_align_buf (FETCH_W=2, ISSUE_W=2, DEPTH=8).
// Expected entries are pushed when a fetch group is driven and popped when decode accepts them.
module tb_fetch_align_buf;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_pc;
    logic        i_cache_vld;
    logic [63:0] i_cache_dat;
    logic        i_flush;
    logic        i_dec_rdy;
    logic        o_fetch_rdy;
    logic [63:0] o_instr;
    logic [63:0] o_pc;
    logic [1:0]  o_instr_vld;
    logic [3:0]  o_count;

    fetch_align_buf #(
        .FETCH_W (2),
        .ISSUE_W (2),
        .DEPTH   (8),
        .XLEN    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pc        (i_pc),
        .i_cache_vld (i_cache_vld),
        .i_cache_dat (i_cache_dat),
        .i_flush     (i_flush),
        .i_dec_rdy   (i_dec_rdy),
        .o_fetch_rdy (o_fetch_rdy),
        .o_instr     (o_instr),
        .o_pc        (o_pc),
        .o_instr_vld (o_instr_vld),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_entry_t sb_q[$];
    logic [31:0]  m_pc;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_rdy();
        return (8 - sb_q.size()) >= 2;
    endfunction

    task automatic check_outputs();
        logic [1:0] exp_vld;
        exp_vld = 2'b00;
        for (int j = 0; j < 2; j++) begin
            if (j < sb_q.size()) exp_vld[j] = 1'b1;
        end
        chk("count", 64'(o_count), 64'(sb_q.size()));
        chk("fetch_rdy", 64'(o_fetch_rdy), 64'(model_rdy()));
        chk("vld", 64'(o_instr_vld), 64'(exp_vld));
        for (int j = 0; j < 2; j++) begin
            if (j < sb_q.size()) begin
                chk("slot_instr", 64'(o_instr[j*32 +: 32]), 64'(sb_q[j].instr));
                chk("slot_pc", 64'(o_pc[j*32 +: 32]), 64'(sb_q[j].pc));
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then check on the falling edge.
    task automatic step(input logic [31:0] pc, input logic cvld, input logic [63:0] dat,
                        input logic flush, input logic rdy);
        bit r;
        int n;
        int off;
        fetch_entry_t e;
        i_pc        = pc;
        i_cache_vld = cvld;
        i_cache_dat = dat;
        i_flush     = flush;
        i_dec_rdy   = rdy;
        r = model_rdy();
        if (flush) begin
            sb_q.delete();
            m_pc = pc;
        end else begin
            if (rdy) begin
                n = (sb_q.size() < 2) ? sb_q.size() : 2;
                repeat (n) void'(sb_q.pop_front());
            end
            if (cvld && r) begin
                off = int'(m_pc[2]);
                for (int k = off; k < 2; k++) begin
                    e.instr = dat[32*k +: 32];
                    e.pc    = {m_pc[31:3], k[0], m_pc[1:0]};
                    sb_q.push_back(e);
                end
            end
            if (r) m_pc = pc;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) begin
            i_pc        = $urandom;
            i_cache_vld = 1'($urandom_range(0, 1));
            i_cache_dat = {$urandom, $urandom};
            i_flush     = 1'($urandom_range(0, 1));
            i_dec_rdy   = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        @(negedge clk);
        sb_q.delete();
        m_pc = 32'h0000_0000;
        chk("rst_pc", o_pc, 64'h0);
        chk("rst_instr", o_instr, 64'h0);
        check_outputs();
        rst_n       = 1'b1;
        i_cache_vld = 1'b0;
        i_flush     = 1'b0;
        i_dec_rdy   = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    logic [63:0] d;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        i_pc = 32'h0; i_cache_vld = 1'b0; i_cache_dat = 64'h0; i_flush = 1'b0; i_dec_rdy = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Aligned group.
        step(32'h100, 1'b0, 64'h0, 1'b0, 1'b0);
        step(32'h108, 1'b1, 64'hBBBB0013_AAAA0013, 1'b0, 1'b0);
        chk("aligned_vld", 64'(o_instr_vld), 64'h3);
        chk("aligned_i0", 64'(o_instr[31:0]), 64'hAAAA0013);
        chk("aligned_pc0", 64'(o_pc[31:0]), 64'h100);
        chk("aligned_i1", 64'(o_instr[63:32]), 64'hBBBB0013);
        chk("aligned_pc1", 64'(o_pc[63:32]), 64'h104);
        chk("aligned_cnt", 64'(o_count), 64'h2);

        // Misaligned group after a redirect.
        step(32'h104, 1'b0, 64'h0, 1'b1, 1'b0);
        step(32'h110, 1'b1, 64'hBBBB0013_AAAA0013, 1'b0, 1'b0);
        chk("mis_vld", 64'(o_instr_vld), 64'h1);
        chk("mis_i0", 64'(o_instr[31:0]), 64'hBBBB0013);
        chk("mis_pc0", 64'(o_pc[31:0]), 64'h104);
        chk("mis_cnt", 64'(o_count), 64'h1);

        // Fill to DEPTH, ignore a fifth group, then drain one issue width.
        step(32'h300, 1'b0, 64'h0, 1'b1, 1'b0);
        for (int g = 0; g < 4; g++) begin
            step(32'h308 + 32'(8 * g), 1'b1, rnd64(), 1'b0, 1'b0);
        end
        chk("full_cnt", 64'(o_count), 64'h8);
        chk("full_rdy", 64'(o_fetch_rdy), 64'h0);
        step(32'h400, 1'b1, rnd64(), 1'b0, 1'b0);
        chk("full_ignore", 64'(o_count), 64'h8);
        step(32'h500, 1'b0, 64'h0, 1'b0, 1'b1);
        chk("drain_cnt", 64'(o_count), 64'h6);
        chk("drain_rdy", 64'(o_fetch_rdy), 64'h1);
        // pc latch held at 0x320 while full; this group must carry PCs 0x320/0x324.
        step(32'h328, 1'b1, rnd64(), 1'b0, 1'b0);
        chk("held_pc", 64'(sb_q[6].pc), 64'h320);

        // Build rd_ptr=7, count=3, then dequeue two while enqueuing two across the wrap.
        step(32'h600, 1'b0, 64'h0, 1'b1, 1'b0);
        step(32'h608, 1'b1, rnd64(), 1'b0, 1'b0);
        step(32'h610, 1'b1, rnd64(), 1'b0, 1'b0);
        step(32'h618, 1'b1, rnd64(), 1'b0, 1'b0);
        repeat (3) step(32'h61C, 1'b0, 64'h0, 1'b0, 1'b1);
        step(32'h620, 1'b1, rnd64(), 1'b0, 1'b0);
        step(32'h62C, 1'b1, rnd64(), 1'b0, 1'b1);
        step(32'h630, 1'b1, rnd64(), 1'b0, 1'b0);
        chk("wrap_pre_cnt", 64'(o_count), 64'h3);
        chk("wrap_pre_pc0", 64'(o_pc[31:0]), 64'h620);
        step(32'h638, 1'b1, rnd64(), 1'b0, 1'b1);
        chk("wrap_cnt", 64'(o_count), 64'h3);
        chk("wrap_pc0", 64'(o_pc[31:0]), 64'h62C);
        chk("wrap_pc1", 64'(o_pc[63:32]), 64'h630);

        // Flush with data arriving in the same cycle.
        step(32'h640, 1'b1, rnd64(), 1'b0, 1'b0);
        chk("pre_flush_cnt", 64'(o_count), 64'h5);
        step(32'h200, 1'b1, rnd64(), 1'b1, 1'b0);
        chk("flush_cnt", 64'(o_count), 64'h0);
        chk("flush_vld", 64'(o_instr_vld), 64'h0);
        d = rnd64();
        step(32'h208, 1'b1, d, 1'b0, 1'b0);
        chk("post_flush_pc0", 64'(o_pc[31:0]), 64'h200);
        chk("post_flush_i0", 64'(o_instr[31:0]), 64'(d[31:0]));

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(32'h1000 + (32'($urandom_range(0, 255)) << 2),
                 1'($urandom_range(0, 1)), rnd64(),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end

        // Mid-operation reset.
        step(32'h700, 1'b0, 64'h0, 1'b1, 1'b0);
        step(32'h708, 1'b1, rnd64(), 1'b0, 1'b0);
        do_reset(1);
        step(32'h800, 1'b0, 64'h0, 1'b0, 1'b0);
        step(32'h808, 1'b1, rnd64(), 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            step(32'h808 + 32'(8 * i), 1'b1, rnd64(), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_align_buf.md
# fetch_align_buf

Parametrised front-end fetch aligner and instruction buffer between the instruction cache and the decode stage of the N-issue core. It registers the fetch PC to line up with the one-cycle cache return and drops fetch-group slots below the PC offset. Surviving instructions are compacted, with their PCs, into a circular queue, and up to ISSUE_W in-order instructions per cycle are presented to decode under ready/valid backpressure. A flush redirects fetch and clears the queue.

## Interface
- FETCH_W, 2: instructions per cache fetch group; power of two.
- ISSUE_W, 2: decode slots; ISSUE_W ≤ DEPTH.
- DEPTH, 8: queue entries; power of two, ≥ 2*FETCH_W.
- XLEN, 32: PC width; instruction width fixed at 32.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- i_pc  in  XLEN  address presented to icache this cycle.
- i_cache_vld  in  1  cache data valid for the previously latched PC.
- i_cache_dat  in  FETCH_W*32  fetch group; slot k at bits [32k+31:32k].
- i_flush  in  1  redirect; i_pc carries the target.
- i_dec_rdy  in  1  decode accepts all valid output slots this cycle.
- o_fetch_rdy  out  1  queue can accept a full group; PC gen/cache stall when low.
- o_instr  out  ISSUE_W*32  output instructions, slot 0 oldest.
- o_pc  out  ISSUE_W*XLEN  PC per output slot.
- o_instr_vld  out  ISSUE_W  thermometer valid, slot 0 first.
- o_count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- pc_q loads i_pc when o_fetch_rdy or i_flush; it holds otherwise.
- Offset off = pc_q[$clog2(FETCH_W)+1:2]. Slots k ≥ off are valid; slot k PC = pc_q with bits [$clog2(FETCH_W)+1:2] replaced by k.
- For FETCH_W=2 this reduces to: slot 0 valid iff pc_q[2]=0, slot 1 always valid.
- Enqueue condition: i_cache_vld & o_fetch_rdy & !i_flush. It writes n_in = FETCH_W-off entries {instr, pc} in slot order at wr_ptr..wr_ptr+n_in-1 (mod DEPTH).
- o_fetch_rdy = (DEPTH - count) ≥ FETCH_W, taken from registered count only.
- Output slot j: valid iff j < count; o_instr/o_pc[j] = mem[(rd_ptr+j) mod DEPTH]. Purely combinational from state.
- Dequeue when i_dec_rdy & !i_flush: n_out = min(count, ISSUE_W); rd_ptr advances by n_out.
- count_next = count + n_in - n_out; enqueue and dequeue in the same cycle are both honoured.
- Flush has priority over everything. Next cycle: count=0, rd_ptr=wr_ptr=0, o_instr_vld=0. Data arriving in the flush cycle is dropped, and nothing dequeues.
- Reset (rst_n=0 at an edge), including mid-operation:
  - pc_q, ptrs, count and all mem entries go to 0.
  - o_instr_vld=0, o_instr=0, o_pc=0, o_count=0, o_fetch_rdy=1.

## Timing
- PC latch at edge t; cache data valid in cycle t+1; written at the end of t+1; visible on the outputs in cycle t+2. There is no bypass.
- Sustained throughput is min(FETCH_W, ISSUE_W) per cycle with aligned PCs.
- Pointer arithmetic is modulo DEPTH ($clog2(DEPTH) bits, natural wrap). count is $clog2(DEPTH+1) bits and never exceeds DEPTH.
- No output is registered beyond the queue state.

## Structure
- Package fetch_pkg holds:
  - ILEN=32.
  - typedef fetch_entry_t {logic [31:0] instr; logic [XLEN-1:0] pc;}.
  - Offset and pointer width helper functions.
- Sub-module fetch_ibuf_mem: DEPTH-entry storage of fetch_entry_t with FETCH_W write ports (base index + per-port enable) and ISSUE_W combinational read ports (base index).
- Top level holds pc_q, the pointers, count, and the valid/ready logic.

## Test plan
- Reset: rst_n=0 for 3 cycles with random inputs -> o_instr_vld=0, o_count=0, o_fetch_rdy=1, o_pc=0.
- Aligned (FETCH_W=2): i_pc=0x100, next cycle dat={0xBBBB0013,0xAAAA0013} valid, i_dec_rdy=0 -> vld=2'b11, slot0 0xAAAA0013 @0x100, slot1 0xBBBB0013 @0x104, count=2.
- Misaligned: i_pc=0x104 -> only 0xBBBB0013 enqueued; slot0 pc=0x104, vld=2'b01, count=1.
- Full: DEPTH=8, i_dec_rdy=0, four aligned groups -> count=8, o_fetch_rdy=0, pc_q holds, a fifth i_cache_vld is ignored. One cycle of i_dec_rdy=1 -> count=6, o_fetch_rdy=1.
- Wrap with simultaneous ops: rd_ptr=7, count=3, i_dec_rdy=1 plus an aligned group -> count stays 3; the two oldest entries (indices 7, 0) leave; program order and PCs are preserved across the wrap.
- Flush: count=5, i_flush=1 with i_cache_vld=1 and i_pc=0x200 -> next cycle count=0, vld=0. The following cycle's data is enqueued with slot0 pc=0x200.
